seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1): iteration counter width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a multiply; sampled on the rising edge.
REQ-006 sign_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start.
REQ-007 A  input  WIDTH  multiplicand; sampled with start.
REQ-008 B  input  WIDTH  multiplier; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse: M is valid.
REQ-011 M  output  2*WIDTH  product.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 A start in IDLE or DONE SHALL be accepted; A, B and sign_mode SHALL be latched, the accumulator and counter cleared, and the FSM SHALL enter RUN.
REQ-014 A start in RUN SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-015 In RUN, each cycle SHALL examine one multiplier bit, LSB first:
  - if the bit is set, add the multiplicand magnitude into the upper half of the accumulator (WIDTH+1-bit sum, carry kept);
  - then shift the accumulator right by one.
REQ-016 RUN SHALL last exactly WIDTH cycles; the counter SHALL terminate at WIDTH-1, then the FSM SHALL enter DONE.
REQ-017 DONE SHALL last one cycle with done=1.
  - Without a new start, the FSM SHALL then go to IDLE.
  - With a start in DONE, the FSM SHALL go to RUN, and done SHALL still pulse in that cycle.
REQ-018 Latency: start sampled at edge t gives busy=1 for cycles t+1..t+WIDTH and done=1 in cycle t+WIDTH+1.
REQ-019 M SHALL update only on entry to DONE, and SHALL hold until the next DONE or reset, including through IDLE and subsequent RUN.
REQ-020 When sign_mode=1:
  - operands SHALL be converted to magnitudes at accept time;
  - the result SHALL be negated (two's complement, 2*WIDTH bits) when exactly one operand is negative.
REQ-021 The most-negative operand (e.g. -8 for WIDTH=4) SHALL be handled as magnitude 2^(WIDTH-1) with no overflow.
  - The 2*WIDTH-bit signed result is always exact.
REQ-022 When sign_mode=0, M SHALL equal the exact unsigned product, with no truncation.
REQ-023 Zero in either operand SHALL still take the full WIDTH cycles; there is no early termination.
REQ-024 busy SHALL be high exactly in RUN, and done SHALL be high exactly in DONE.

Reset
REQ-025 On rst=1, asynchronously and regardless of state:
  - FSM goes to IDLE;
  - busy=0, done=0, M=0;
  - accumulator, counter, latched operands and sign flag are cleared.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-027 A start in the first edge after reset release SHALL be accepted normally.

Structure
REQ-028 Shared package mult_pkg SHALL hold the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH range limits.
REQ-029 The add step SHALL use one sub-module, adder_nbit: parametrised WIDTH ripple-carry adder, ports A, B, C_in, S, C_out, purely combinational.
REQ-030 Magnitude conversion and final negation SHALL be combinational logic in seq_multiplier; no additional sub-modules.
REQ-031 Estimated size: 150-250 RTL lines.

Verification
REQ-032 WIDTH=4, unsigned, A=15, B=15, single start -> busy high for 4 cycles; done in cycle t+5; M=225 (0xE1).
REQ-033 WIDTH=4, signed, A=-8 (4'h8), B=-8 -> M=64 (8'h40); signed A=-3, B=5 -> M=-15 (8'hF1); signed A=7, B=0 -> M=0 after the full 4 cycles.
REQ-034 WIDTH=4: start A=3, B=2, then start pulses A=15, B=15 during RUN -> ignored; M=6; a single done pulse.
REQ-035 WIDTH=4: back-to-back operations, with start asserted in the DONE cycle of (A=5, B=3) for (A=9, B=9) -> done pulses give M=15, then 4 cycles later M=81; no idle cycle between.
REQ-036 WIDTH=4: rst asserted in the 2nd RUN cycle -> busy, done and M are 0 immediately (asynchronously); no done pulse after release; the next start (A=2, B=6) gives M=12.
REQ-037 WIDTH=8, 1000 random operands in both modes compared against a reference product; check M held stable between done pulses.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encodings and legal operand widths.
package mult_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_nbit.sv
// Parametrised ripple-carry adder used for the multiplier's add step; purely combinational.
module adder_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = C_in;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign S[gi]         = A[gi] ^ B[gi] ^ carry[gi];
    assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
  end

  assign C_out = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: one multiplier bit per cycle, unsigned or two's-complement operands,
// sign handled by magnitude conversion on accept and negation of the final product.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] M
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_multiplier: WIDTH out of range");
  end

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg;
  logic                 neg_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   m_reg;

  logic                 accept;
  logic                 last_iter;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     addend, sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   acc_next, prod_final;

  assign accept    = start && (state_reg != RUN);
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Most-negative value maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  assign a_mag = (sign_mode && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_mag = (sign_mode && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  // Upper half accumulates partial sums; lower half starts as the multiplier magnitude and is
  // consumed LSB first while product bits shift in behind it.
  assign addend = acc_reg[0] ? mcand_reg : '0;

  adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .A     (acc_reg[2*WIDTH-1:WIDTH]),
    .B     (addend),
    .C_in  (1'b0),
    .S     (sum),
    .C_out (carry)
  );

  assign acc_next   = {carry, sum, acc_reg[WIDTH-1:1]};
  assign prod_final = neg_reg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      neg_reg   <= 1'b0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      m_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mcand_reg <= a_mag;
        neg_reg   <= sign_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
        acc_reg   <= {{WIDTH{1'b0}}, b_mag};
        cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (last_iter) m_reg <= prod_final;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign M    = m_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: WIDTH=4 directed table and corner sequences, WIDTH=8 random scoreboard run.
module tb_seq_multiplier;

  logic clk, rst;
  logic start4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] m4;
  logic start8, sm8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] m8;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done4_cnt = 0;
  int hold_err = 0;
  logic [7:0] exp_q4[$];
  logic [15:0] exp_q8[$];
  logic [15:0] held8 = '0;

  typedef struct {
    logic       sm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] m;
  } vec_t;
  vec_t vecs[12];

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sign_mode(sm4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .M(m4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sign_mode(sm8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .M(m8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    else pass_cnt++;
  endtask

  // Scoreboard side: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (done4) begin
      done4_cnt++;
      if (exp_q4.size() == 0) check("w4_unexpected_done", 64'(m4), 64'hFFFF_FFFF);
      else begin
        logic [7:0] e4;
        e4 = exp_q4.pop_front();
        $display("txn w4: M=%h expected=%h", m4, e4);
        check("w4_product", 64'(m4), 64'(e4));
      end
    end
    if (done8) begin
      held8 = m8;
      if (exp_q8.size() == 0) check("w8_unexpected_done", 64'(m8), 64'hFFFF_FFFF);
      else begin
        logic [15:0] e8;
        e8 = exp_q8.pop_front();
        $display("txn w8: M=%h expected=%h", m8, e8);
        check("w8_product", 64'(m8), 64'(e8));
      end
    end else if (m8 !== held8) begin
      hold_err++;
    end
  end

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] m, input string nm);
    bit ok;
    ok = 1'b1;
    start4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
    exp_q4.push_back(m);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (busy4 !== 1'b1 || done4 !== 1'b0) ok = 1'b0;
    end
    check({nm, "_busy_window"}, 64'(ok), 64'd1);
    @(negedge clk);
    check({nm, "_done_latency"}, {62'd0, done4, busy4}, 64'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vecs[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
    vecs[1]  = '{1'b1, 4'h8, 4'h8, 8'h40};
    vecs[2]  = '{1'b1, 4'hD, 4'h5, 8'hF1};
    vecs[3]  = '{1'b1, 4'h7, 4'h0, 8'h00};
    vecs[4]  = '{1'b0, 4'h0, 4'h9, 8'h00};
    vecs[5]  = '{1'b0, 4'h8, 4'hF, 8'h78};
    vecs[6]  = '{1'b1, 4'h7, 4'h8, 8'hC8};
    vecs[7]  = '{1'b1, 4'hF, 4'hF, 8'h01};
    vecs[8]  = '{1'b0, 4'h1, 4'h1, 8'h01};
    vecs[9]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
    vecs[10] = '{1'b0, 4'hF, 4'h1, 8'h0F};
    vecs[11] = '{1'b1, 4'hF, 4'h1, 8'hFF};

    rst = 1'b1;
    start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    check("reset_w4", {54'd0, busy4, done4, m4}, 64'd0);
    check("reset_w8", {46'd0, busy8, done8, m8}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      run_op4(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].m, $sformatf("vec%0d", i));
    end

    // Back-to-back: second start lands in the DONE cycle of the first.
    @(negedge clk);
    run_op4(1'b0, 4'd5, 4'd3, 8'd15, "b2b_first");
    run_op4(1'b0, 4'd9, 4'd9, 8'd81, "b2b_second");

    // Starts during RUN must be ignored.
    @(negedge clk);
    d0 = done4_cnt;
    start4 = 1'b1; sm4 = 1'b0; a4 = 4'd3; b4 = 4'd2;
    exp_q4.push_back(8'd6);
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    check("ign_done_at_t5", 64'(done4), 64'd1);
    repeat (8) @(negedge clk);
    check("ign_single_done", 64'(done4_cnt - d0), 64'd1);
    check("ign_idle_after", {62'd0, busy4, done4}, 64'd0);

    // Reset in the second RUN cycle aborts; M held through RUN until then.
    @(negedge clk);
    start4 = 1'b1; sm4 = 1'b0; a4 = 4'd7; b4 = 4'd7;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    check("m_hold_in_run", 64'(m4), 64'd6);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {54'd0, busy4, done4, m4}, 64'd0);
    d0 = done4_cnt;
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_no_done", 64'(done4_cnt - d0), 64'd0);

    // Start on the first edge after reset release.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_op4(1'b0, 4'd2, 4'd6, 8'd12, "post_rst");
    repeat (2) @(negedge clk);
    check("w4_queue_drained", 64'(exp_q4.size()), 64'd0);

    // WIDTH=8 random operands in both modes.
    for (int i = 0; i < 1000; i++) begin
      int ia, ib, n;
      logic rsm;
      logic [7:0] ra, rb;
      rsm = (i % 2 == 1);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (rsm) begin ia = int'($signed(ra)); ib = int'($signed(rb)); end
      else begin ia = int'(ra); ib = int'(rb); end
      @(negedge clk);
      start8 = 1'b1; sm8 = rsm; a8 = ra; b8 = rb;
      exp_q8.push_back(16'(ia * ib));
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 20) begin @(negedge clk); n++; end
      if (!done8) check("w8_done_timeout", 64'd0, 64'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("w8_queue_drained", 64'(exp_q8.size()), 64'd0);
    check("w8_m_hold_stable", 64'(hold_err), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
